// File: rtl/seq_calculator.sv
// Handshaked unsigned calculator: add/sub finish in one cycle, mul/div share an
// iterative shift-add / restoring shift-subtract datapath over WIDTH cycles.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     first_num,
  input  logic [WIDTH-1:0]     second_num,
  input  logic [1:0]           operation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     a_reg;     // multiplier (mul) or dividend/quotient (div), shifted each step
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 is_mul;

  logic [WIDTH:0]       rem_shift, rem_diff;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_next, quo_next;
  logic [2*WIDTH-1:0]   acc_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) begin
        if (operation == OP_MUL || (operation == OP_DIV && second_num != '0))
          state_next = CALC;
        else
          state_next = DONE;
      end
      CALC:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of each algorithm; only the one matching is_mul is committed.
  always_comb begin
    acc_next  = acc + (a_reg[0] ? mcand : '0);
    rem_shift = {rem, a_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_reg};
    rem_ge    = (rem_shift >= {1'b0, b_reg});
    rem_next  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {a_reg[WIDTH-2:0], rem_ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      rem         <= '0;
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
      is_mul      <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg  <= first_num;
          b_reg  <= second_num;
          mcand  <= {{WIDTH{1'b0}}, second_num};
          acc    <= '0;
          rem    <= '0;
          cnt    <= CNT_W'(WIDTH);
          is_mul <= (operation == OP_MUL);
          case (operation)
            OP_ADD: begin
              result      <= {{WIDTH{1'b0}}, first_num} + {{WIDTH{1'b0}}, second_num};
              div_by_zero <= 1'b0;
            end
            OP_SUB: begin
              result      <= {{WIDTH{1'b0}}, first_num} - {{WIDTH{1'b0}}, second_num};
              div_by_zero <= 1'b0;
            end
            OP_DIV: if (second_num == '0) begin
              result      <= {first_num, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
            end
            default: ;
          endcase
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_mul) begin
            acc   <= acc_next;
            a_reg <= a_reg >> 1;
            mcand <= mcand << 1;
          end else begin
            rem   <= rem_next;
            a_reg <= quo_next;
          end
          // Last iteration: load the value being formed this cycle.
          if (cnt == CNT_W'(1)) begin
            result      <= is_mul ? acc_next : {rem_next, quo_next};
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Self-checking bench for seq_calculator: WIDTH=8 and WIDTH=16 instances checked
// against an arithmetic reference model with directed and random operations.
module tb_seq_calculator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b0, dz8, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  op8 = '0;
  logic [15:0] res8;

  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b0, dz16, busy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [1:0]  op16 = '0;
  logic [31:0] res16;

  seq_calculator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .first_num(a8), .second_num(b8), .operation(op8),
    .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .div_by_zero(dz8), .busy(busy8)
  );

  seq_calculator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .first_num(a16), .second_num(b16), .operation(op16),
    .out_valid(ov16), .out_ready(ordy16), .result(res16),
    .div_by_zero(dz16), .busy(busy16)
  );

  // Reference: plain arithmetic on w-bit unsigned operands.
  function automatic longint unsigned model(input int w, input logic [1:0] op,
                                            input longint unsigned a, input longint unsigned b,
                                            output logic dz);
    longint unsigned m2, m1;
    m2 = (64'd1 << (2 * w)) - 64'd1;
    m1 = (64'd1 << w) - 64'd1;
    dz = 1'b0;
    case (op)
      2'd0: return a + b;
      2'd1: return (a - b) & m2;
      2'd2: return a * b;
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          return (a << w) | m1;
        end
        return ((a % b) << w) | (a / b);
      end
    endcase
  endfunction

  function automatic int exp_lat(input int w, input logic [1:0] op, input longint unsigned b);
    return (op == 2'd2 || (op == 2'd3 && b != 0)) ? w + 1 : 1;
  endfunction

  // Issue one op on the 8-bit DUT, pulse in_valid during CALC, optionally
  // stall the consumer for 'hold' cycles, then complete the handshake.
  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int hold, output logic [15:0] res, output logic dz, output int lat);
    int guard;
    logic ready_leak;
    guard = 0;
    while (!ir8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (ir8 !== 1'b1) begin
      failures++;
      $display("FAIL run8_wait_ready in_ready=%b expected 1", ir8);
    end
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b; ordy8 = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
    lat = 1;
    ready_leak = 1'b0;
    while (!ov8 && lat < 100) begin
      if (ir8 || !busy8) ready_leak = 1'b1;
      iv8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    iv8 = 1'b0;
    checks++;
    if (ov8 !== 1'b1 || ready_leak || busy8 !== 1'b1) begin
      failures++;
      $display("FAIL run8_calc out_valid=%b busy=%b ready_leak=%b expected 1/1/0", ov8, busy8, ready_leak);
    end
    res = res8;
    dz  = dz8;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b1 || res8 !== res || dz8 !== dz) begin
        failures++;
        $display("FAIL backpressure_hold out_valid=%b result=%h dz=%b expected 1/%h/%b", ov8, res8, dz8, res, dz);
      end
    end
    ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL run8_after_handshake in_ready=%b out_valid=%b expected 1/0", ir8, ov8);
    end
  endtask

  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] res, output logic dz, output int lat);
    iv16 = 1'b1; op16 = op; a16 = a; b16 = b; ordy16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!ov16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = res16;
    dz  = dz16;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check8(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold);
    logic [15:0] res, exp_res;
    logic dz, exp_dz;
    int lat, elat;
    exp_res = 16'(model(8, op, 64'(a), 64'(b), exp_dz));
    elat = exp_lat(8, op, 64'(b));
    run8(op, a, b, hold, res, dz, lat);
    checks++;
    if (res !== exp_res || dz !== exp_dz || lat != elat) begin
      failures++;
      $display("FAIL %s op=%0d a=%0d b=%0d got res=%h dz=%b lat=%0d expected res=%h dz=%b lat=%0d",
               name, op, a, b, res, dz, lat, exp_res, exp_dz, elat);
    end
  endtask

  task automatic check16(input string name, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    logic [31:0] res, exp_res;
    logic dz, exp_dz;
    int lat, elat;
    exp_res = 32'(model(16, op, 64'(a), 64'(b), exp_dz));
    elat = exp_lat(16, op, 64'(b));
    run16(op, a, b, res, dz, lat);
    checks++;
    if (res !== exp_res || dz !== exp_dz || lat != elat) begin
      failures++;
      $display("FAIL %s op=%0d a=%0d b=%0d got res=%h dz=%b lat=%0d expected res=%h dz=%b lat=%0d",
               name, op, a, b, res, dz, lat, exp_res, exp_dz, elat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || res8 !== 16'h0 || dz8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8 ir=%b ov=%b res=%h dz=%b busy=%b expected 1/0/0000/0/0", ir8, ov8, res8, dz8, busy8);
    end
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || res16 !== 32'h0 || dz16 !== 1'b0 || busy16 !== 1'b0) begin
      failures++;
      $display("FAIL reset16 ir=%b ov=%b res=%h dz=%b busy=%b expected 1/0/0/0/0", ir16, ov16, res16, dz16, busy16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [15:0] res;
    logic dz;
    int lat;
    run8(2'd0, 8'd200, 8'd100, 0, res, dz, lat);
    checks++;
    if (res !== 16'h012C || dz !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL add_200_100 res=%h dz=%b lat=%0d expected 012c/0/1", res, dz, lat);
    end
    run8(2'd1, 8'd230, 8'd111, 0, res, dz, lat);
    checks++;
    if (res !== 16'd119 || dz !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL sub_230_111 res=%h dz=%b lat=%0d expected 0077/0/1", res, dz, lat);
    end
    run8(2'd1, 8'd100, 8'd200, 0, res, dz, lat);
    checks++;
    if (res !== 16'hFF9C || lat != 1) begin
      failures++;
      $display("FAIL sub_100_200 res=%h lat=%0d expected ff9c/1", res, lat);
    end
  endtask

  task automatic test_mul();
    logic [15:0] res;
    logic dz;
    int lat;
    run8(2'd2, 8'd202, 8'd101, 0, res, dz, lat);
    checks++;
    if (res !== 16'd20402 || dz !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL mul_202_101 res=%0d dz=%b lat=%0d expected 20402/0/9", res, dz, lat);
    end
    check8("mul_zero_a", 2'd2, 8'd0, 8'd77, 0);
    check8("mul_zero_b", 2'd2, 8'd91, 8'd0, 0);
  endtask

  task automatic test_div();
    logic [15:0] res;
    logic dz;
    int lat;
    run8(2'd3, 8'd210, 8'd110, 0, res, dz, lat);
    checks++;
    if (res !== 16'h6401 || dz !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL div_210_110 res=%h dz=%b lat=%0d expected 6401/0/9", res, dz, lat);
    end
    run8(2'd3, 8'd5, 8'd7, 0, res, dz, lat);
    checks++;
    if (res !== 16'h0500 || lat != 9) begin
      failures++;
      $display("FAIL div_5_7 res=%h lat=%0d expected 0500/9", res, lat);
    end
    run8(2'd3, 8'd200, 8'd0, 0, res, dz, lat);
    checks++;
    if (res !== 16'hC8FF || dz !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL div_by_zero res=%h dz=%b lat=%0d expected c8ff/1/1", res, dz, lat);
    end
    // div_by_zero must clear on the next loaded result.
    check8("dz_clears", 2'd0, 8'd4, 8'd4, 0);
  endtask

  task automatic test_backpressure();
    check8("mul_max_backpressure", 2'd2, 8'd255, 8'd255, 5);
    check8("div_backpressure", 2'd3, 8'd255, 8'd16, 3);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    iv8 = 1'b1; op8 = 2'd3; a8 = 8'd210; b8 = 8'd110; ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || res8 !== 16'h0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_op ir=%b ov=%b res=%h busy=%b expected 1/0/0000/0", ir8, ov8, res8, busy8);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_stale_valid out_valid_cycles=%0d expected 0", seen);
    end
    check8("add_after_reset", 2'd0, 8'd1, 8'd2, 0);
  endtask

  task automatic test_back_to_back();
    int accepts;
    // Hold in_valid and out_ready high: add ops complete every second cycle.
    accepts = 0;
    iv8 = 1'b1; op8 = 2'd0; a8 = 8'd9; b8 = 8'd8; ordy8 = 1'b1;
    repeat (10) begin
      @(posedge clk);
      if (ir8) accepts++;
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (accepts != 5) begin
      failures++;
      $display("FAIL back_to_back accepts=%0d expected 5", accepts);
    end
    check8("b2b_follow", 2'd1, 8'd0, 8'd1, 0);
  endtask

  task automatic test_random8();
    logic [1:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      case ($urandom_range(0, 7))
        0: b = 8'd0;
        1: a = 8'd0;
        2: begin a = 8'hFF; b = 8'hFF; end
        3: if (a > 8'd1) b = a - 8'd1;
        default: ;
      endcase
      check8("random8", op, a, b, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_width16();
    check16("mul16_max", 2'd2, 16'hFFFF, 16'hFFFF);
    check16("div16_50000_7", 2'd3, 16'd50000, 16'd7);
    check16("div16_zero", 2'd3, 16'd1234, 16'd0);
    check16("sub16_neg", 2'd1, 16'd3, 16'd60000);
    for (int i = 0; i < 12; i++)
      check16("random16", 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_random8();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
